// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with a valid/ready handshake.
// Holds one beat in the main entry and, when SKID=1, a second beat in a skid
// entry so that in_ready comes straight from a flop. Control bits selected by
// KILL_MASK are cleared on bubble beats. Flush drops every held beat. A
// saturating counter records the cycles in which the output is stalled.
module pipe_stage_reg #(
  parameter int                 DATA_W    = 96,
  parameter int                 CTRL_W    = 16,
  parameter logic [CTRL_W-1:0]  KILL_MASK = {CTRL_W{1'b1}},
  parameter bit                 SKID      = 1'b1,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bubble,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_valid_r, main_valid_s;
  logic [DATA_W-1:0] main_data_r,  main_data_s;
  logic [CTRL_W-1:0] main_ctrl_r,  main_ctrl_s;
  logic              skid_valid_r, skid_valid_s;
  logic [DATA_W-1:0] skid_data_r,  skid_data_s;
  logic [CTRL_W-1:0] skid_ctrl_r,  skid_ctrl_s;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic              in_ready_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic [CTRL_W-1:0] in_ctrl_s;

  // Upstream ready: a flop-driven term with a skid entry, else pass-through of downstream ready.
  always_comb begin
    if (SKID) begin
      in_ready_s = ~skid_valid_r;
    end else begin
      in_ready_s = ~main_valid_r | out_ready;
    end
  end

  assign in_fire_s  = in_valid & in_ready_s;
  assign out_fire_s = main_valid_r & out_ready;

  // Bubble beats keep their payload but lose the killable control bits.
  always_comb begin
    if (in_bubble) begin
      in_ctrl_s = in_ctrl & ~KILL_MASK;
    end else begin
      in_ctrl_s = in_ctrl;
    end
  end

  // Next state of the main and skid entries; flush overrides every transfer.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    main_ctrl_s  = main_ctrl_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    skid_ctrl_s  = skid_ctrl_r;
    if (flush) begin
      main_valid_s = 1'b0;
      main_data_s  = '0;
      main_ctrl_s  = '0;
      skid_valid_s = 1'b0;
      skid_data_s  = '0;
      skid_ctrl_s  = '0;
    end else if (SKID) begin
      if (!main_valid_r) begin
        // Skid is never occupied while main is empty.
        if (in_fire_s) begin
          main_valid_s = 1'b1;
          main_data_s  = in_data;
          main_ctrl_s  = in_ctrl_s;
        end else begin
          main_valid_s = 1'b0;
        end
      end else if (out_fire_s) begin
        if (skid_valid_r) begin
          main_data_s  = skid_data_r;
          main_ctrl_s  = skid_ctrl_r;
          skid_valid_s = 1'b0;
        end else if (in_fire_s) begin
          main_data_s  = in_data;
          main_ctrl_s  = in_ctrl_s;
        end else begin
          main_valid_s = 1'b0;
        end
      end else begin
        // Main is stalled; a new beat can only arrive when skid is empty.
        if (in_fire_s) begin
          skid_valid_s = 1'b1;
          skid_data_s  = in_data;
          skid_ctrl_s  = in_ctrl_s;
        end else begin
          skid_valid_s = skid_valid_r;
        end
      end
    end else begin
      if (in_fire_s) begin
        main_valid_s = 1'b1;
        main_data_s  = in_data;
        main_ctrl_s  = in_ctrl_s;
      end else if (out_fire_s) begin
        main_valid_s = 1'b0;
      end else begin
        main_valid_s = main_valid_r;
      end
    end
  end

  // Entry registers; reset discards any held beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_r <= 1'b0;
      main_data_r  <= '0;
      main_ctrl_r  <= '0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_ctrl_r  <= '0;
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      main_ctrl_r  <= main_ctrl_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      skid_ctrl_r  <= skid_ctrl_s;
    end
  end

  // Saturating stall counter; survives flush so stalls across redirects still accumulate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= '0;
    end else if (main_valid_r && !out_ready && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;
  assign out_ctrl  = main_ctrl_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 instance with KILL_MASK=16'h000F checked
// through a scoreboard queue, and a SKID=0 / CNT_W=4 instance for saturation
// and combinational ready.
module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid, in_ready, in_bubble, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [15:0]   stall_cnt;

  logic          in_valid0, in_ready0, in_bubble0, out_valid0, out_ready0;
  logic [DW-1:0] in_data0, out_data0;
  logic [CW-1:0] in_ctrl0, out_ctrl0;
  logic [3:0]    stall_cnt0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(16'h000F), .SKID(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_bubble(in_bubble),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(16'hFFFF), .SKID(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_bubble(in_bubble0),
    .in_data(in_data0), .in_ctrl(in_ctrl0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_ctrl(out_ctrl0), .stall_cnt(stall_cnt0)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          bub;
    logic [CW-1:0] exp_c;
  } vec_t;

  beat_t       sb[$];
  vec_t        tbl[8];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_stall;
  logic [15:0] stall_base;
  logic [CW-1:0] exp_ctrl_cur;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic bub, input logic [CW-1:0] ec);
    in_valid     = v;
    in_data      = d;
    in_ctrl      = c;
    in_bubble    = bub;
    exp_ctrl_cur = ec;
  endtask

  // One clock: observe handshakes mid-cycle, update scoreboard and stall model, advance.
  task automatic tick();
    beat_t b;
    beat_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_beat: got %0h expected none", out_data);
      end else begin
        e = sb.pop_front();
        chk("sb_data", 128'(out_data), 128'(e.d));
        chk("sb_ctrl", 128'(out_ctrl), 128'(e.c));
      end
    end
    if (out_valid && !out_ready && exp_stall != 16'hFFFF) exp_stall++;
    if (flush) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      b.d = in_data;
      b.c = exp_ctrl_cur;
      sb.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 1'b0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("drain_sb_empty", 128'(sb.size()), 128'(0));
    #1;
    chk("drain_idle", 128'(out_valid), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{d: 96'd1, c: 16'hFFFF, bub: 1'b1, exp_c: 16'hFFF0};
    tbl[1] = '{d: 96'd2, c: 16'h1234, bub: 1'b0, exp_c: 16'h1234};
    tbl[2] = '{d: 96'd3, c: 16'h00AB, bub: 1'b1, exp_c: 16'h00A0};
    tbl[3] = '{d: 96'd4, c: 16'h000F, bub: 1'b1, exp_c: 16'h0000};
    tbl[4] = '{d: 96'd5, c: 16'hFFFF, bub: 1'b0, exp_c: 16'hFFFF};
    tbl[5] = '{d: 96'd6, c: 16'h5A5A, bub: 1'b1, exp_c: 16'h5A50};
    tbl[6] = '{d: 96'd7, c: 16'h8001, bub: 1'b1, exp_c: 16'h8000};
    tbl[7] = '{d: 96'd8, c: 16'h0F0F, bub: 1'b0, exp_c: 16'h0F0F};

    reset = 1'b0; flush = 1'b0; out_ready = 1'b0; exp_stall = 16'd0;
    drive(1'b0, '0, '0, 1'b0, '0);
    in_valid0 = 1'b0; in_bubble0 = 1'b0; in_data0 = '0; in_ctrl0 = '0; out_ready0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_stall_cnt", 128'(stall_cnt), 128'(0));
    reset = 1'b1;
    #1;
    chk("release_in_ready", 128'(in_ready), 128'(1));

    // 1: reset while main and skid both hold beats
    drive(1'b1, 96'hAAA1, 16'h0101, 1'b0, 16'h0101); tick();
    drive(1'b1, 96'hAAA2, 16'h0202, 1'b0, 16'h0202); tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    #1;
    chk("full_in_ready", 128'(in_ready), 128'(0));
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    sb.delete();
    exp_stall = 16'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    chk("post_rst_out_valid", 128'(out_valid), 128'(0));

    // 2: streaming with table vectors (mixes bubbles with KILL_MASK=16'h000F)
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].d, tbl[i].c, tbl[i].bub, tbl[i].exp_c);
      #1;
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      if (i > 0) chk("stream_out_valid", 128'(out_valid), 128'(1));
      tick();
    end
    drain();

    // 4: explicit bubble beat held at the output
    out_ready = 1'b0;
    drive(1'b1, 96'h1234_5678_9ABC, 16'hFFFF, 1'b1, 16'hFFF0); tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    #1;
    chk("bubble_ctrl", 128'(out_ctrl), 128'(16'hFFF0));
    chk("bubble_valid", 128'(out_valid), 128'(1));
    chk("bubble_data", 128'(out_data), 128'(96'h1234_5678_9ABC));
    drain();

    // 3: back-pressure fills skid and blocks the third beat
    out_ready = 1'b0;
    stall_base = exp_stall;
    drive(1'b1, 96'hA, 16'h0A0A, 1'b0, 16'h0A0A); tick();
    drive(1'b1, 96'hB, 16'h0B0B, 1'b0, 16'h0B0B); tick();
    drive(1'b1, 96'hC, 16'h0C0C, 1'b0, 16'h0C0C);
    #1;
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_hold_a", 128'(out_data), 128'(96'hA));
    tick();
    chk("bp_stall_delta", 128'(stall_cnt - stall_base), 128'(2));
    out_ready = 1'b1;
    tick();
    tick();
    drain();
    chk("bp_stall_model", 128'(stall_cnt), 128'(exp_stall));

    // 5: flush with skid full, then flush together with an accepted beat
    out_ready = 1'b0;
    drive(1'b1, 96'hD1, 16'h1111, 1'b0, 16'h1111); tick();
    drive(1'b1, 96'hD2, 16'h2222, 1'b0, 16'h2222); tick();
    drive(1'b1, 96'hD3, 16'h3333, 1'b0, 16'h3333);
    flush = 1'b1; tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    #1;
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("flush_out_data", 128'(out_data), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    chk("flush_stall_cnt", 128'(stall_cnt), 128'(exp_stall));
    drive(1'b1, 96'hE1, 16'h4444, 1'b0, 16'h4444); tick();
    drive(1'b1, 96'hE2, 16'h5555, 1'b0, 16'h5555);
    #1;
    chk("flush_fire_in_ready", 128'(in_ready), 128'(1));
    flush = 1'b1; tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    #1;
    chk("flush2_out_valid", 128'(out_valid), 128'(0));
    chk("flush2_in_ready", 128'(in_ready), 128'(1));
    drive(1'b1, 96'hF1, 16'h6666, 1'b0, 16'h6666); tick();
    drain();
    chk("flush_stall_model", 128'(stall_cnt), 128'(exp_stall));

    // 6: SKID=0 instance, ready follows out_ready, counter saturates at 15
    in_valid0 = 1'b1; in_data0 = 96'h5EED; in_ctrl0 = 16'h00C3; out_ready0 = 1'b0;
    #1;
    chk("s0_in_ready_empty", 128'(in_ready0), 128'(1));
    @(negedge clk);
    in_valid0 = 1'b0;
    #1;
    chk("s0_out_valid", 128'(out_valid0), 128'(1));
    chk("s0_out_data", 128'(out_data0), 128'(96'h5EED));
    chk("s0_out_ctrl", 128'(out_ctrl0), 128'(16'h00C3));
    chk("s0_in_ready_stall", 128'(in_ready0), 128'(0));
    repeat (20) @(negedge clk);
    #1;
    chk("s0_stall_sat", 128'(stall_cnt0), 128'(15));
    out_ready0 = 1'b1;
    #1;
    chk("s0_in_ready_follow", 128'(in_ready0), 128'(1));
    @(negedge clk);
    #1;
    chk("s0_drained", 128'(out_valid0), 128'(0));
    chk("s0_stall_hold", 128'(stall_cnt0), 128'(15));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
